// File: rtl/axi_rd_arb_pkg.sv
// Shared definitions for the AXI read arbiter: FSM state encoding, helper
// status codes (match the AXI helper defines) and a small status decode helper.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic [1:0] RD_STATUS_READY = 2'd0;
  localparam logic [1:0] RD_STATUS_WAIT  = 2'd1;
  localparam logic [1:0] RD_STATUS_OK    = 2'd2;
  localparam logic [1:0] RD_STATUS_ERR   = 2'd3;

  localparam int BURST_LEN_WIDTH = 4;

  // True when the helper reports a finished transaction (ok or error).
  function automatic logic status_final(input logic [1:0] status);
    return (status == RD_STATUS_OK) || (status == RD_STATUS_ERR);
  endfunction

endpackage

// File: rtl/axi_rd_arb_if.sv
// Bus between the read arbiter (master) and the AXI read helper (slave).
interface axi_rd_arb_if #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDR_WIDTH    = 32,
  parameter int BUS_WIDTH     = 32,
  parameter int MAX_BURST_LEN = 1
);
  logic                               rd_enable;
  logic [ID_WIDTH-1:0]                rd_id;
  logic [ADDR_WIDTH-1:0]              rd_addr;
  logic [3:0]                         rd_burst_len;
  logic [2:0]                         rd_burst_size;
  logic [MAX_BURST_LEN*BUS_WIDTH-1:0] rd_data;
  logic [1:0]                         rd_status;

  modport master (
    output rd_enable, rd_id, rd_addr, rd_burst_len, rd_burst_size,
    input  rd_data, rd_status
  );

  modport slave (
    input  rd_enable, rd_id, rd_addr, rd_burst_len, rd_burst_size,
    output rd_data, rd_status
  );
endinterface

// File: rtl/axi_rd_arb_rr_pick.sv
// Round-robin winner selection: search starts one past last_owner and wraps.
// Purely combinational; the caller registers the result.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  int               sum_s;
  int               cand_int_s;
  logic [IDX_W-1:0] cand_s;

  // Scan from farthest to nearest candidate so the nearest requester wins last.
  always_comb begin
    sum_s      = 0;
    cand_int_s = 0;
    cand_s     = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      sum_s      = int'(last_owner) + i;
      cand_int_s = (sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s;
      cand_s     = IDX_W'(cand_int_s);
      pick_idx   = req_vec[cand_s] ? cand_s : pick_idx;
      pick_valid = req_vec[cand_s] | pick_valid;
    end
    pick_onehot = pick_valid ? (NUM_REQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/axi_rd_arb.sv
// AXI read arbiter: shares one AXI read helper among NUM_REQ requesters,
// one transaction outstanding at a time (IDLE -> ISSUE -> WAIT -> DONE).
// Optional macro AXI_RD_ARB_PRIORITY_EN: requester 0 always wins in IDLE,
// the remaining requesters round-robin among themselves.
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int NUM_REQ              = 2,
  parameter int AXI_RD_ID_WIDTH      = 8,
  parameter int AXI_RD_ADDR_WIDTH    = 32,
  parameter int AXI_RD_BUS_WIDTH     = 32,
  parameter int AXI_RD_MAX_BURST_LEN = 1,
  parameter int BASE_ID              = 0
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic [NUM_REQ-1:0]                           req,
  input  logic [NUM_REQ*AXI_RD_ADDR_WIDTH-1:0]         req_addr,
  input  logic [NUM_REQ*BURST_LEN_WIDTH-1:0]           req_burst_len,
  output logic [NUM_REQ-1:0]                           grant,
  output logic [NUM_REQ-1:0]                           done,
  output logic                                         err,
  output logic [AXI_RD_MAX_BURST_LEN*AXI_RD_BUS_WIDTH-1:0] resp_data,
  axi_rd_arb_if.master                                 rd_bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DATA_W = AXI_RD_MAX_BURST_LEN * AXI_RD_BUS_WIDTH;
  localparam logic [2:0] BURST_SIZE = 3'($clog2(AXI_RD_BUS_WIDTH / 8));

  arb_state_t                  state_r, state_s;
  logic [NUM_REQ-1:0]          grant_r, grant_s;
  logic [NUM_REQ-1:0]          done_r, done_s;
  logic                        err_r, err_s;
  logic [DATA_W-1:0]           resp_data_r, resp_data_s;
  logic                        rd_enable_r, rd_enable_s;
  logic [AXI_RD_ID_WIDTH-1:0]  rd_id_r, rd_id_s;
  logic [AXI_RD_ADDR_WIDTH-1:0] rd_addr_r, rd_addr_s;
  logic [BURST_LEN_WIDTH-1:0]  rd_len_r, rd_len_s;
  logic [IDX_W-1:0]            last_owner_r, last_owner_s;

  logic [NUM_REQ-1:0]          pick_req_s;
  logic [NUM_REQ-1:0]          rr_onehot_s;
  logic [IDX_W-1:0]            rr_idx_s;
  logic                        rr_valid_s;
  logic [NUM_REQ-1:0]          win_onehot_s;
  logic [IDX_W-1:0]            win_idx_s;
  logic                        win_valid_s;
  logic [AXI_RD_ADDR_WIDTH-1:0] sel_addr_s;
  logic [BURST_LEN_WIDTH-1:0]  sel_len_s;

`ifdef AXI_RD_ARB_PRIORITY_EN
  assign pick_req_s = {req[NUM_REQ-1:1], 1'b0};
`else
  assign pick_req_s = req;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_vec     (pick_req_s),
    .last_owner  (last_owner_r),
    .pick_onehot (rr_onehot_s),
    .pick_idx    (rr_idx_s),
    .pick_valid  (rr_valid_s)
  );

  // Final winner: requester 0 overrides round-robin when priority is built in.
  always_comb begin
    win_onehot_s = rr_onehot_s;
    win_idx_s    = rr_idx_s;
    win_valid_s  = rr_valid_s;
`ifdef AXI_RD_ARB_PRIORITY_EN
    if (req[0]) begin
      win_onehot_s = NUM_REQ'(1);
      win_idx_s    = '0;
      win_valid_s  = 1'b1;
    end else begin
      win_onehot_s = rr_onehot_s;
      win_idx_s    = rr_idx_s;
      win_valid_s  = rr_valid_s;
    end
`endif
  end

  // AND-OR mux of the winner's address and burst length slices.
  always_comb begin
    sel_addr_s = '0;
    sel_len_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_addr_s = sel_addr_s |
        (req_addr[k*AXI_RD_ADDR_WIDTH +: AXI_RD_ADDR_WIDTH] & {AXI_RD_ADDR_WIDTH{win_onehot_s[k]}});
      sel_len_s  = sel_len_s |
        (req_burst_len[k*BURST_LEN_WIDTH +: BURST_LEN_WIDTH] & {BURST_LEN_WIDTH{win_onehot_s[k]}});
    end
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    done_s       = '0;
    err_s        = err_r;
    resp_data_s  = resp_data_r;
    rd_enable_s  = 1'b0;
    rd_id_s      = rd_id_r;
    rd_addr_s    = rd_addr_r;
    rd_len_s     = rd_len_r;
    last_owner_s = last_owner_r;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s && (rd_bus.rd_status == RD_STATUS_READY)) begin
          grant_s      = win_onehot_s;
          rd_id_s      = AXI_RD_ID_WIDTH'(BASE_ID) + AXI_RD_ID_WIDTH'(win_idx_s);
          rd_addr_s    = sel_addr_s;
          rd_len_s     = sel_len_s;
          rd_enable_s  = 1'b1;
          last_owner_s = win_idx_s;
          state_s      = ST_ISSUE;
        end else begin
          grant_s = '0;
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (status_final(rd_bus.rd_status)) begin
          resp_data_s = rd_bus.rd_data;
          err_s       = (rd_bus.rd_status == RD_STATUS_ERR);
          done_s      = grant_r;
          state_s     = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        grant_s = '0;
        state_s = ST_IDLE;
      end
      default: begin
        grant_s = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      done_r       <= '0;
      err_r        <= 1'b0;
      resp_data_r  <= '0;
      rd_enable_r  <= 1'b0;
      rd_id_r      <= '0;
      rd_addr_r    <= '0;
      rd_len_r     <= '0;
      last_owner_r <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      done_r       <= done_s;
      err_r        <= err_s;
      resp_data_r  <= resp_data_s;
      rd_enable_r  <= rd_enable_s;
      rd_id_r      <= rd_id_s;
      rd_addr_r    <= rd_addr_s;
      rd_len_r     <= rd_len_s;
      last_owner_r <= last_owner_s;
    end
  end

  assign grant                = grant_r;
  assign done                 = done_r;
  assign err                  = err_r;
  assign resp_data            = resp_data_r;
  assign rd_bus.rd_enable     = rd_enable_r;
  assign rd_bus.rd_id         = rd_id_r;
  assign rd_bus.rd_addr       = rd_addr_r;
  assign rd_bus.rd_burst_len  = rd_len_r;
  assign rd_bus.rd_burst_size = BURST_SIZE;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed testbench for axi_rd_arb with three requesters; the bench plays
// the AXI read helper by driving rd_status/rd_data on the interface.
module tb_axi_rd_arb;

`ifdef AXI_RD_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic [2:0]  req;
  logic [95:0] req_addr;
  logic [11:0] req_burst_len;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        err;
  logic [31:0] resp_data;

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  axi_rd_arb_if #(.ID_WIDTH(8), .ADDR_WIDTH(32), .BUS_WIDTH(32), .MAX_BURST_LEN(1)) rd_bus ();

  axi_rd_arb #(
    .NUM_REQ(3), .AXI_RD_ID_WIDTH(8), .AXI_RD_ADDR_WIDTH(32),
    .AXI_RD_BUS_WIDTH(32), .AXI_RD_MAX_BURST_LEN(1), .BASE_ID(0)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req           (req),
    .req_addr      (req_addr),
    .req_burst_len (req_burst_len),
    .grant         (grant),
    .done          (done),
    .err           (err),
    .resp_data     (resp_data),
    .rd_bus        (rd_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full transaction starting in IDLE; exp_g is the expected owner.
  task automatic do_txn(input logic [2:0] req_v, input logic drop, input logic [2:0] exp_g,
                        input logic [1:0] st, input logic [31:0] data, input int wait_cyc);
    int          idx;
    logic [31:0] e_addr;
    logic [3:0]  e_len;
    logic [95:0] addr_keep;
    idx = (exp_g == 3'b001) ? 0 : (exp_g == 3'b010) ? 1 : 2;
    e_addr = 32'h1000 * (idx + 1);
    e_len  = (idx == 0) ? 4'd0 : (idx == 1) ? 4'd3 : 4'd7;
    addr_keep = req_addr;
    req = req_v;
    rd_bus.rd_status = 2'd0;
    tick();
    chk("issue_en",    64'(rd_bus.rd_enable), 64'(1'b1));
    chk("issue_grant", 64'(grant), 64'(exp_g));
    chk("issue_id",    64'(rd_bus.rd_id), 64'(idx));
    chk("issue_addr",  64'(rd_bus.rd_addr), 64'(e_addr));
    chk("issue_len",   64'(rd_bus.rd_burst_len), 64'(e_len));
    rd_bus.rd_status = 2'd1;
    tick();
    chk("wait_en",    64'(rd_bus.rd_enable), 64'(1'b0));
    chk("wait_grant", 64'(grant), 64'(exp_g));
    if (drop) begin
      req = 3'b000;
      req_addr = ~req_addr;
    end
    for (int w = 0; w < wait_cyc; w++) begin
      tick();
      chk("wait_done", 64'(done), 64'(3'b000));
    end
    rd_bus.rd_status = st;
    rd_bus.rd_data = data;
    tick();
    chk("done_pulse", 64'(done), 64'(exp_g));
    chk("done_err",   64'(err), 64'(st == 2'd3));
    chk("done_data",  64'(resp_data), 64'(data));
    chk("done_grant", 64'(grant), 64'(exp_g));
    chk("done_addr",  64'(rd_bus.rd_addr), 64'(e_addr));
    rd_bus.rd_status = 2'd0;
    rd_bus.rd_data = 32'h0BAD_F00D;
    req_addr = addr_keep;
    tick();
    chk("idle_done",  64'(done), 64'(3'b000));
    chk("idle_grant", 64'(grant), 64'(3'b000));
    chk("idle_data",  64'(resp_data), 64'(data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req = 3'b000;
    req_addr = {32'h3000, 32'h2000, 32'h1000};
    req_burst_len = {4'd7, 4'd3, 4'd0};
    rd_bus.rd_status = 2'd0;
    rd_bus.rd_data = 32'h0;
    tick();
    tick();
    chk("rst_grant", 64'(grant), 64'(3'b000));
    chk("rst_done",  64'(done), 64'(3'b000));
    chk("rst_err",   64'(err), 64'(1'b0));
    chk("rst_en",    64'(rd_bus.rd_enable), 64'(1'b0));
    chk("rst_data",  64'(resp_data), 64'(32'h0));
    chk("burst_size", 64'(rd_bus.rd_burst_size), 64'(3'd2));
    reset_n = 1'b1;

    // Helper not ready: no arbitration.
    req = 3'b001;
    rd_bus.rd_status = 2'd1;
    tick();
    chk("busy_en",    64'(rd_bus.rd_enable), 64'(1'b0));
    chk("busy_grant", 64'(grant), 64'(3'b000));
    tick();
    chk("busy_grant2", 64'(grant), 64'(3'b000));

    // Single transaction.
    do_txn(3'b001, 1'b0, 3'b001, 2'd2, 32'hDEAD_BEEF, 0);
    // Two-way contention held continuously.
    do_txn(3'b011, 1'b0, PRIO ? 3'b001 : 3'b010, 2'd2, 32'h1111_0001, 1);
    do_txn(3'b011, 1'b0, 3'b001,                 2'd2, 32'h1111_0002, 0);
    do_txn(3'b011, 1'b0, PRIO ? 3'b001 : 3'b010, 2'd2, 32'h1111_0003, 2);
    // Error followed by ok.
    do_txn(3'b100, 1'b0, 3'b100, 2'd3, 32'hEEEE_0001, 0);
    do_txn(3'b100, 1'b0, 3'b100, 2'd2, 32'hEEEE_0002, 1);
    // Three-way contention.
    do_txn(3'b111, 1'b0, 3'b001,                 2'd2, 32'h2222_0001, 0);
    do_txn(3'b111, 1'b0, PRIO ? 3'b001 : 3'b010, 2'd2, 32'h2222_0002, 0);
    do_txn(3'b111, 1'b0, PRIO ? 3'b001 : 3'b100, 2'd2, 32'h2222_0003, 0);
    do_txn(3'b111, 1'b0, 3'b001,                 2'd2, 32'h2222_0004, 0);
    // Request dropped during WAIT still completes once.
    do_txn(3'b010, 1'b1, 3'b010, 2'd2, 32'h3333_0001, 1);
    tick();
    chk("drop_idle_grant", 64'(grant), 64'(3'b000));
    chk("drop_idle_en",    64'(rd_bus.rd_enable), 64'(1'b0));
    chk("drop_idle_done",  64'(done), 64'(3'b000));

    // Reset in the middle of WAIT.
    req = 3'b001;
    tick();
    chk("pre_rst_grant", 64'(grant), 64'(3'b001));
    rd_bus.rd_status = 2'd1;
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(grant), 64'(3'b000));
    chk("mid_rst_en",    64'(rd_bus.rd_enable), 64'(1'b0));
    chk("mid_rst_addr",  64'(rd_bus.rd_addr), 64'(32'h0));
    chk("mid_rst_id",    64'(rd_bus.rd_id), 64'(8'h0));
    chk("mid_rst_len",   64'(rd_bus.rd_burst_len), 64'(4'd0));
    chk("mid_rst_data",  64'(resp_data), 64'(32'h0));
    chk("mid_rst_err",   64'(err), 64'(1'b0));
    chk("mid_rst_done",  64'(done), 64'(3'b000));
    req = 3'b000;
    rd_bus.rd_status = 2'd0;
    tick();
    chk("in_rst_done", 64'(done), 64'(3'b000));
    reset_n = 1'b1;
    // last_owner back to 2, so requester 0 wins first.
    do_txn(3'b011, 1'b0, 3'b001, 2'd2, 32'h4444_0001, 0);
    do_txn(3'b010, 1'b0, 3'b010, 2'd2, 32'h4444_0002, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/axi_rd_arb.md
AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 Parameter NUM_REQ, default 2; number of requesters, legal 2..4.
REQ-002 Parameter AXI_RD_ID_WIDTH, default 8; read ID width.
REQ-003 Parameter AXI_RD_ADDR_WIDTH, default 32; address width.
REQ-004 Parameter AXI_RD_BUS_WIDTH, default 32; data beat width.
REQ-005 Parameter AXI_RD_MAX_BURST_LEN, default 1; max beats per transaction.
REQ-006 Parameter BASE_ID, default 0; ID issued for requester k is BASE_ID+k.
REQ-007 Clock/reset: one clock; reset is asynchronous and active-low; ports are clock and reset_n.
REQ-008 clock  in  1  rising-edge clock.
REQ-009 reset_n  in  1  async active-low reset.
REQ-010 req  in  NUM_REQ  per-requester read request level.
REQ-011 req_addr  in  NUM_REQ*AXI_RD_ADDR_WIDTH  per-requester start address, slice k.
REQ-012 req_burst_len  in  NUM_REQ*4  per-requester burst_len (beats-1), slice k.
REQ-013 grant  out  NUM_REQ  one-hot owner of the read path; zero when idle.
REQ-014 done  out  NUM_REQ  one-cycle completion pulse to owner.
REQ-015 err  out  1  valid with done; 1 = transaction returned error.
REQ-016 resp_data  out  AXI_RD_MAX_BURST_LEN*AXI_RD_BUS_WIDTH  read data, valid with done, held until next done.
REQ-017 rd_enable  out  1  start strobe to the AXI read helper.
REQ-018 rd_id, rd_addr, rd_burst_len  out  ID/ADDR/4  transaction fields to helper, held stable from ISSUE through DONE.
REQ-019 rd_burst_size  out  3  constant log2(AXI_RD_BUS_WIDTH/8).
REQ-020 rd_data  in  AXI_RD_MAX_BURST_LEN*AXI_RD_BUS_WIDTH  helper data.
REQ-021 rd_status  in  2  helper status: 0 ready, 1 wait, 2 ok, 3 error.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT, DONE; one transaction outstanding at most.
REQ-023 IDLE: if any req bit set and rd_status==0, select winner, register grant/rd_id/rd_addr/rd_burst_len, assert rd_enable, go ISSUE; else stay.
REQ-024 ISSUE lasts exactly one cycle with rd_enable=1; next edge rd_enable=0, go WAIT.
REQ-025 WAIT: on edge with rd_status>=2, capture rd_data to resp_data, err=(rd_status==3), go DONE; rd_status 0/1 stays WAIT.
REQ-026 DONE lasts one cycle: done[owner]=1, grant held; no arbitration; next edge grant=0, go IDLE.
REQ-027 Latency: req high at edge N in IDLE -> rd_enable high cycle N+1; done high the cycle after rd_status>=2 observed.
REQ-028 Round-robin: search starts at index last_owner+1 modulo NUM_REQ; last_owner updated on each grant.
REQ-029 Requester holds req and fields stable until done; dropping req mid-transaction does not abort; done still pulses.
REQ-030 Fields of non-owners and req changes outside IDLE are ignored.
REQ-031 Back-to-back: requester may reassert req the cycle after done; it re-enters arbitration in IDLE.

Reset
REQ-032 Reset: state IDLE, grant=0, done=0, err=0, rd_enable=0, rd_id/rd_addr/rd_burst_len=0, resp_data=0, last_owner=NUM_REQ-1.
REQ-033 Reset mid-transaction abandons it; no done issued; helper is reset by the same reset_n.

Configuration
REQ-034 Macro AXI_RD_ARB_PRIORITY_EN defined: requester 0 wins whenever it requests in IDLE; others round-robin among themselves.
REQ-035 Macro undefined: pure round-robin over all requesters per REQ-028.

Structure
REQ-036 Shared package/header holds FSM state encodings and status constants (READY=0, WAIT=1, OK=2, ERR=3), consistent with existing AXI defines.
REQ-037 Winner selection is a sub-module rr_pick (req vector, last_owner in; one-hot and index out).

Verification
REQ-038 Single: NUM_REQ=2, req=01, addr0=0x1000, len=0, helper returns 0xDEADBEEF ok -> rd_enable 1 cycle, rd_id=0, done=01, err=0, resp_data=0xDEADBEEF.
REQ-039 Contention: req=11 held continuously -> grants alternate 01,10,01,10; rd_id alternates 0,1.
REQ-040 Error: helper returns status 3 -> done pulse with err=1; next transaction ok -> err=0.
REQ-041 Priority macro defined, NUM_REQ=3, req=111 held -> requester 0 granted every transaction; without macro 0,1,2,0.
REQ-042 Req dropped during WAIT -> transaction completes, done pulses once, next IDLE idle.
REQ-043 reset_n low during WAIT -> all outputs reset values same cycle; after release req=10 -> grant 10 first.
